// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter that lets NCORES cores share one memory port.
//   One transaction is in flight at a time; each completes with a
//   single-cycle one-hot rvalid pulse to the owning core.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req[NCORES]           per-core request, held stable while stall is high
//   req_write[NCORES]     per-core store (1) / load (0)
//   req_addr, req_wdata   per-core 32-bit address / store data, core i at [32i+31:32i]
//   stall[NCORES]         per-core hold, req & ~rvalid
//   rvalid[NCORES]        one-hot completion pulse
//   rdata[32]             last load data, broadcast to all cores
//   mem_req/mem_write/mem_addr/mem_wdata   shared memory request
//   mem_ack/mem_rdata     memory response, rdata valid with ack
//   grant_id[IDW]         index of the core owning the port
//
// state  | meaning
// S_IDLE | no transaction; arbitrate among req bits
// S_BUSY | mem_req high, request fields frozen, waiting for mem_ack
// S_DONE | rvalid pulse to grant_id; requests ignored this cycle

module mem_arbiter #(
  parameter int NCORES = 4,
  parameter int IDW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    req_write,
  input  logic [32*NCORES-1:0] req_addr,
  input  logic [32*NCORES-1:0] req_wdata,
  output logic [NCORES-1:0]    stall,
  output logic [NCORES-1:0]    rvalid,
  output logic [31:0]          rdata,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_cand;

  // Walk the search order backwards so the earliest candidate after r_last
  // is the one left standing. NCORES is a power of two, so the IDW-bit add
  // wraps exactly like mod NCORES; k = NCORES lands back on r_last itself.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int k = NCORES; k >= 1; k--) begin
      w_cand = r_last + IDW'(k);
      if (req[w_cand]) w_winner = w_cand;
    end
  end

  assign stall = req & ~rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= IDW'(NCORES - 1);
      grant_id  <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            grant_id  <= w_winner;
            mem_write <= req_write[w_winner];
            mem_addr  <= req_addr[{w_winner, 5'b0} +: 32];
            mem_wdata <= req_wdata[{w_winner, 5'b0} +: 32];
            mem_req   <= 1'b1;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A granted core dropping req here does not abort; only ack ends BUSY.
          if (mem_ack) begin
            if (!mem_write) rdata <= mem_rdata;
            r_last  <= grant_id;
            mem_req <= 1'b0;
            rvalid  <= {{(NCORES-1){1'b0}}, 1'b1} << grant_id;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          rvalid  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          rvalid  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (NCORES=4). A transaction-level
//   reference model (round-robin pick from the last completed core, plus the
//   expected rdata) predicts every grant; directed scenarios are followed by
//   randomized request/ack traffic.

module tb_mem_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_write = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    stall;
  logic [N-1:0]    rvalid;
  logic [31:0]     rdata;
  logic            mem_req;
  logic            mem_write;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic [IDW-1:0]  grant_id;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_last;
  logic [31:0] m_rdata;
  time         g_done_t;

  always #5 clk = ~clk;

  mem_arbiter #(.NCORES(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First requesting core after 'last', wrapping around.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_core(input int c, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req[c]             = 1'b1;
    req_write[c]       = wr;
    req_addr[32*c +: 32]  = a;
    req_wdata[32*c +: 32] = wd;
  endtask

  // Entered at a negedge with the DUT idle and at least one req set;
  // returns at the negedge after DONE (DUT idle again).
  task automatic run_txn(input int d, input logic [31:0] rd, input bit drop_mid,
                         input bit spur, input bit keep, output int who);
    int          w;
    logic [31:0] a, wd;
    logic        wr;
    logic [N-1:0] oh;
    w = rr_pick(req, m_last);
    if (w < 0) begin
      check_val("pick_none", 32'd1, 32'd0);
      who = -1;
      return;
    end
    a  = req_addr[32*w +: 32];
    wd = req_wdata[32*w +: 32];
    wr = req_write[w];
    oh = N'(1) << w;
    #1 check_val("stall_idle", stall, req);
    @(negedge clk);
    who = int'(grant_id);
    check_val("grant", grant_id, w);
    check_val("busy_req", mem_req, 1);
    check_val("busy_addr", mem_addr, a);
    check_val("busy_write", mem_write, wr);
    check_val("busy_wdata", mem_wdata, wd);
    check_val("busy_rvalid", rvalid, 0);
    if (drop_mid) req[w] = 1'b0;
    #1 check_val("stall_busy", stall, req);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check_val("hold_req", mem_req, 1);
      check_val("hold_addr", mem_addr, a);
      check_val("hold_wdata", mem_wdata, wd);
      check_val("hold_rvalid", rvalid, 0);
      check_val("hold_stall", stall[w], req[w]);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    m_last = w;
    if (!wr) m_rdata = rd;
    g_done_t = $time;
    check_val("done_rvalid", rvalid, oh);
    check_val("done_req", mem_req, 0);
    check_val("done_rdata", rdata, m_rdata);
    check_val("stall_done", stall, req & ~oh);
    if (!keep) req[w] = 1'b0;
    mem_ack = spur;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("idle_rvalid", rvalid, 0);
    check_val("idle_req", mem_req, 0);
    check_val("idle_rdata", rdata, m_rdata);
  endtask

  initial begin
    int  who;
    int  exp_order [5] = '{0, 1, 2, 3, 0};
    time prev_t;

    m_last  = N - 1;
    m_rdata = '0;
    req     = 4'b1011;

    // Reset values while held in reset
    #1;
    check_val("rst_req", mem_req, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_grant", grant_id, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_write", mem_write, 0);
    check_val("rst_stall", stall, req);
    @(negedge clk);
    rst = 1'b0;

    // Fairness: all cores request continuously, ack in first BUSY cycle
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 32'h1000 + 32'(c * 16), 32'h0);
    prev_t = 0;
    for (int i = 0; i < 5; i++) begin
      run_txn(0, $urandom, 1'b0, 1'b0, 1'b1, who);
      check_val("rr_order", who, exp_order[i]);
      if (i > 0) check_val("rr_spacing", 32'(g_done_t - prev_t), 32'd30);
      prev_t = g_done_t;
    end
    req = '0;
    @(negedge clk);

    // Single load from core 1, ack on the second BUSY cycle
    set_core(1, 1'b0, 32'h100, 32'h0);
    run_txn(1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, who);
    check_val("load_rdata", rdata, 32'hDEADBEEF);

    // Store from core 2 leaves rdata untouched
    set_core(2, 1'b1, 32'h40, 32'h55AA);
    run_txn(0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, who);
    check_val("store_rdata", rdata, 32'hDEADBEEF);

    // Spurious ack while idle with no requests
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("spur_req", mem_req, 0);
    check_val("spur_rvalid", rvalid, 0);
    check_val("spur_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    check_val("spur_idle", mem_req, 0);

    // Reset asserted between edges while core 3 is in BUSY
    set_core(3, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    check_val("pre_rst_grant", grant_id, 3);
    check_val("pre_rst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_req", mem_req, 0);
    check_val("async_grant", grant_id, 0);
    check_val("async_addr", mem_addr, 0);
    check_val("async_stall", stall, req);
    m_last  = N - 1;
    m_rdata = '0;
    @(negedge clk);
    rst     = 1'b0;
    req     = '0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check_val("late_ack_rvalid", rvalid, 0);
    check_val("late_ack_req", mem_req, 0);
    check_val("late_ack_rdata", rdata, 0);
    set_core(3, 1'b0, 32'h300, 32'h0);
    run_txn(2, 32'h33333333, 1'b0, 1'b0, 1'b0, who);
    check_val("regrant3", who, 3);

    // Wrap-around: last is 3, only core 2 requests
    set_core(2, 1'b0, 32'h200, 32'h0);
    run_txn(0, 32'h22222222, 1'b0, 1'b0, 1'b0, who);
    check_val("wrap_grant", who, 2);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < N; c++) begin
        if (!req[c] && $urandom_range(0, 1) == 1)
          set_core(c, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      if (req == '0) set_core(int'($urandom_range(0, N-1)), 1'b0, $urandom, $urandom);
      run_txn(int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 1) == 1), 1'b0, who);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
